// File: rtl/pit_pkg.sv
// Shared encodings, state types and the control-word builder for the pit8254 host sequencer.
package pit_pkg;

    localparam logic [1:0] OP_PROGRAM  = 2'b00;
    localparam logic [1:0] OP_LATCH    = 2'b01;
    localparam logic [1:0] OP_SET_GATE = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB   = 2'b01;
    localparam logic [1:0] RW_MSB   = 2'b10;
    localparam logic [1:0] RW_BOTH  = 2'b11;

    localparam logic [1:0] ADDR_CTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_CTRL = 3'd1,
        ST_WR_LSB  = 3'd2,
        ST_WR_MSB  = 3'd3,
        ST_RD_LSB  = 3'd4,
        ST_RD_MSB  = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        BC_IDLE   = 2'd0,
        BC_SETUP  = 2'd1,
        BC_STROBE = 2'd2,
        BC_HOLD   = 2'd3
    } bc_phase_t;

    function automatic logic [7:0] ctrl_word(input logic [1:0] ch, input logic [1:0] rw,
                                             input logic [2:0] mode, input logic bcd);
        return {ch, rw, mode, bcd};
    endfunction

    // Channel 3 never exists; rw=00 is only meaningful as a latch command, never as a request format.
    function automatic logic req_bad(input logic [1:0] op, input logic [1:0] ch, input logic [1:0] rw);
        return (op == OP_RSVD) || (ch == 2'b11) || ((op != OP_SET_GATE) && (rw == RW_LATCH));
    endfunction

endpackage

// File: rtl/pit_bus_cycle.sv
// Single pit8254 bus access engine: setup, STB_CYCLES of strobe, hold; back-to-back starts allowed from hold.
module pit_bus_cycle
    import pit_pkg::*;
#(
    parameter int STB_CYCLES     = 2,
    parameter int STB_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_read,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic [7:0] pit_di,
    input  logic [7:0] pit_do,
    output logic       pit_cs,
    output logic       pit_wr,
    output logic       pit_rd,
    output logic       pit_a0,
    output logic       pit_a1
);

    localparam logic       LVL_IDLE = (STB_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic       LVL_ACT  = ~LVL_IDLE;
    localparam logic [7:0] STB_LAST = 8'(STB_CYCLES - 1);

    bc_phase_t  phase_r;
    logic [7:0] cnt_r;
    logic       rd_op_r;
    logic       cs_r, wr_r, rd_r;
    logic [1:0] addr_r;
    logic [7:0] di_r;
    logic [7:0] rdata_r;

    // Access phase sequencing with all bus pins driven straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= BC_IDLE;
            cnt_r   <= 8'd0;
            rd_op_r <= 1'b0;
            cs_r    <= LVL_IDLE;
            wr_r    <= LVL_IDLE;
            rd_r    <= LVL_IDLE;
            addr_r  <= 2'b00;
            di_r    <= 8'h00;
            rdata_r <= 8'h00;
        end else begin
            case (phase_r)
                BC_IDLE, BC_HOLD: begin
                    if (start) begin
                        phase_r <= BC_SETUP;
                        cs_r    <= LVL_ACT;
                        addr_r  <= addr;
                        di_r    <= is_read ? 8'h00 : wdata;
                        rd_op_r <= is_read;
                    end else begin
                        phase_r <= BC_IDLE;
                        cs_r    <= LVL_IDLE;
                        addr_r  <= 2'b00;
                        di_r    <= 8'h00;
                        rd_op_r <= 1'b0;
                    end
                end
                BC_SETUP: begin
                    phase_r <= BC_STROBE;
                    cnt_r   <= 8'd0;
                    if (rd_op_r) rd_r <= LVL_ACT;
                    else         wr_r <= LVL_ACT;
                end
                BC_STROBE: begin
                    // Read data is captured on the edge that closes the last strobe cycle.
                    if (cnt_r == STB_LAST) begin
                        phase_r <= BC_HOLD;
                        wr_r    <= LVL_IDLE;
                        rd_r    <= LVL_IDLE;
                        if (rd_op_r) rdata_r <= pit_do;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    phase_r <= BC_IDLE;
                    cs_r    <= LVL_IDLE;
                    wr_r    <= LVL_IDLE;
                    rd_r    <= LVL_IDLE;
                end
            endcase
        end
    end

    assign done   = (phase_r == BC_HOLD);
    assign rdata  = rdata_r;
    assign pit_di = di_r;
    assign pit_cs = cs_r;
    assign pit_wr = wr_r;
    assign pit_rd = rd_r;
    assign pit_a1 = addr_r[1];
    assign pit_a0 = addr_r[0];

endmodule

// File: rtl/pit_sequencer.sv
// Expands one host request at a time into pit8254 control/data bus accesses; owns gate0..2.
module pit_sequencer
    import pit_pkg::*;
#(
    parameter int STB_CYCLES     = 2,
    parameter int STB_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_ch,
    input  logic [1:0]  req_rw,
    input  logic [2:0]  req_mode,
    input  logic        req_bcd,
    input  logic [15:0] req_count,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic [7:0]  pit_di,
    input  logic [7:0]  pit_do,
    output logic        pit_cs,
    output logic        pit_wr,
    output logic        pit_rd,
    output logic        pit_a0,
    output logic        pit_a1,
    output logic [2:0]  gate
);

    seq_state_t  state_r, state_s;
    logic [1:0]  op_r, ch_r, rw_r;
    logic [15:0] count_r;
    logic [7:0]  lsb_r;
    logic        rsp_valid_r, rsp_err_r, req_ready_r;
    logic [15:0] rsp_data_r;
    logic [2:0]  gate_r;

    logic        accept_s, bad_s, access_s;
    logic        bc_start_s, bc_read_s, bc_done_s;
    logic [1:0]  bc_addr_s;
    logic [7:0]  bc_wdata_s, bc_rdata_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);
    assign bad_s    = req_bad(req_op, req_ch, req_rw);

    // Phase state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Next phase: data phases are skipped according to the latched access format.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s)                             state_s = ST_IDLE;
                else if (bad_s || (req_op == OP_SET_GATE)) state_s = ST_DONE;
                else                                       state_s = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                if (!bc_done_s)            state_s = ST_WR_CTRL;
                else if (op_r == OP_LATCH) state_s = rw_r[0] ? ST_RD_LSB : ST_RD_MSB;
                else                       state_s = rw_r[0] ? ST_WR_LSB : ST_WR_MSB;
            end
            ST_WR_LSB: begin
                if (bc_done_s) state_s = rw_r[1] ? ST_WR_MSB : ST_DONE;
                else           state_s = ST_WR_LSB;
            end
            ST_RD_LSB: begin
                if (bc_done_s) state_s = rw_r[1] ? ST_RD_MSB : ST_DONE;
                else           state_s = ST_RD_LSB;
            end
            ST_WR_MSB, ST_RD_MSB: begin
                if (bc_done_s) state_s = ST_DONE;
                else           state_s = state_r;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Access request to the bus engine, issued on the edge that enters each access phase.
    always_comb begin
        bc_read_s  = 1'b0;
        bc_addr_s  = 2'b00;
        bc_wdata_s = 8'h00;
        access_s   = 1'b1;
        case (state_s)
            ST_WR_CTRL: begin
                bc_addr_s = ADDR_CTRL;
                if (req_op == OP_LATCH) bc_wdata_s = ctrl_word(req_ch, RW_LATCH, 3'b000, 1'b0);
                else                    bc_wdata_s = ctrl_word(req_ch, req_rw, req_mode, req_bcd);
            end
            ST_WR_LSB: begin
                bc_addr_s  = ch_r;
                bc_wdata_s = count_r[7:0];
            end
            ST_WR_MSB: begin
                bc_addr_s  = ch_r;
                bc_wdata_s = count_r[15:8];
            end
            ST_RD_LSB, ST_RD_MSB: begin
                bc_addr_s = ch_r;
                bc_read_s = 1'b1;
            end
            default: access_s = 1'b0;
        endcase
        if (access_s && ((state_r == ST_IDLE) || bc_done_s)) bc_start_s = 1'b1;
        else                                                 bc_start_s = 1'b0;
    end

    // Request capture, read assembly, gate register and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r        <= 2'b00;
            ch_r        <= 2'b00;
            rw_r        <= 2'b00;
            count_r     <= 16'h0000;
            lsb_r       <= 8'h00;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= 16'h0000;
            gate_r      <= 3'b000;
            req_ready_r <= 1'b1;
        end else begin
            if (accept_s) begin
                op_r    <= req_op;
                ch_r    <= req_ch;
                rw_r    <= req_rw;
                count_r <= req_count;
            end
            if (bc_done_s && (state_r == ST_RD_LSB)) lsb_r <= bc_rdata_s;
            if ((state_s == ST_DONE) && (state_r == ST_RD_LSB))
                rsp_data_r <= {8'h00, bc_rdata_s};
            else if ((state_s == ST_DONE) && (state_r == ST_RD_MSB))
                rsp_data_r <= {bc_rdata_s, (rw_r[0] ? lsb_r : 8'h00)};
            if (accept_s && !bad_s && (req_op == OP_SET_GATE)) begin
                for (int i = 0; i < 3; i++) begin
                    if (req_ch == 2'(i)) gate_r[i] <= req_count[0];
                end
            end
            rsp_valid_r <= (state_s == ST_DONE);
            rsp_err_r   <= accept_s && bad_s;
            req_ready_r <= (state_s == ST_IDLE);
        end
    end

    pit_bus_cycle #(
        .STB_CYCLES     (STB_CYCLES),
        .STB_ACTIVE_LOW (STB_ACTIVE_LOW)
    ) u_bus (
        .clk     (clk),
        .reset   (reset),
        .start   (bc_start_s),
        .is_read (bc_read_s),
        .addr    (bc_addr_s),
        .wdata   (bc_wdata_s),
        .rdata   (bc_rdata_s),
        .done    (bc_done_s),
        .pit_di  (pit_di),
        .pit_do  (pit_do),
        .pit_cs  (pit_cs),
        .pit_wr  (pit_wr),
        .pit_rd  (pit_rd),
        .pit_a0  (pit_a0),
        .pit_a1  (pit_a1)
    );

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_data  = rsp_data_r;
    assign gate      = gate_r;

endmodule

// File: tb/tb_pit_sequencer.sv
// Scoreboard bench for pit_sequencer: directed requests push expected bus accesses and responses.
module tb_pit_sequencer;
    import pit_pkg::*;

    localparam int STB = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00, req_ch = 2'b00, req_rw = 2'b00;
    logic [2:0]  req_mode = 3'b000;
    logic        req_bcd = 1'b0;
    logic [15:0] req_count = 16'h0000;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic [7:0]  pit_di, pit_do;
    logic        pit_cs, pit_wr, pit_rd, pit_a0, pit_a1;
    logic [2:0]  gate;

    pit_sequencer #(.STB_CYCLES(STB), .STB_ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_ch(req_ch), .req_rw(req_rw), .req_mode(req_mode),
        .req_bcd(req_bcd), .req_count(req_count), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .pit_di(pit_di), .pit_do(pit_do), .pit_cs(pit_cs),
        .pit_wr(pit_wr), .pit_rd(pit_rd), .pit_a0(pit_a0), .pit_a1(pit_a1), .gate(gate)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic rd; logic [1:0] a; logic [7:0] d; } bus_t;
    typedef struct { logic err; logic chk_data; logic [15:0] data; logic [2:0] gate; int cyc; } rsp_t;
    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Toy counter model: successive read strobes return these latched bytes in order.
    int rd_idx = 0;
    function automatic logic [7:0] rd_byte(input int i);
        case (i)
            0:       return 8'h34;
            1:       return 8'h12;
            2:       return 8'h5A;
            3:       return 8'hC3;
            default: return 8'hEE;
        endcase
    endfunction
    assign pit_do = rd_byte(rd_idx);

    // Bus monitor: checks each access against the expected queue and its strobe timing.
    logic wr_a, rd_a, cs_a, in_stb = 1'b0, prev_setup = 1'b0;
    int   stb_len = 0, acc_seen = 0, cs_cycles = 0;
    bus_t cur;
    always @(negedge clk) begin
        if (reset) begin
            in_stb = 1'b0;
            prev_setup = 1'b0;
        end else begin
            wr_a = !pit_wr; rd_a = !pit_rd; cs_a = !pit_cs;
            if (cs_a) cs_cycles++;
            if (wr_a && rd_a) chk("wr_rd_exclusive", {wr_a, rd_a}, 2'b01);
            if ((wr_a || rd_a) && !in_stb) begin
                acc_seen++;
                if (bus_q.size() == 0) begin
                    chk("unexpected_access", bus_q.size(), 1);
                    cur.rd = rd_a;
                end else begin
                    cur = bus_q.pop_front();
                    chk("access_kind", rd_a, cur.rd);
                    chk("access_addr", {pit_a1, pit_a0}, cur.a);
                    chk("access_di", pit_di, cur.rd ? 8'h00 : cur.d);
                    chk("access_cs", cs_a, 1'b1);
                    chk("access_setup", prev_setup, 1'b1);
                end
                in_stb = 1'b1;
                stb_len = 1;
            end else if (wr_a || rd_a) begin
                stb_len++;
            end else if (in_stb) begin
                chk("strobe_len", stb_len, STB);
                chk("hold_cs", cs_a, 1'b1);
                if (cur.rd) rd_idx++;
                in_stb = 1'b0;
            end
            prev_setup = cs_a && !wr_a && !rd_a;
        end
    end

    // Response monitor: pops an expectation on each rsp_valid; gate is checked the cycle after.
    logic       gate_pend = 1'b0;
    logic [2:0] gate_exp;
    rsp_t       rr;
    always @(negedge clk) begin
        if (reset) begin
            gate_pend = 1'b0;
        end else begin
            if (gate_pend) chk("gate", gate, gate_exp);
            gate_pend = 1'b0;
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 1'b0);
                end else begin
                    rr = rsp_q.pop_front();
                    chk("rsp_cycle", cyc, rr.cyc);
                    chk("rsp_err", rsp_err, rr.err);
                    chk("rsp_ready_low", req_ready, 1'b0);
                    if (rr.chk_data) chk("rsp_data", rsp_data, rr.data);
                    gate_exp  = rr.gate;
                    gate_pend = 1'b1;
                end
            end
        end
    end

    task automatic exp_w(input logic [1:0] a, input logic [7:0] d);
        bus_t b;
        b.rd = 1'b0; b.a = a; b.d = d;
        bus_q.push_back(b);
    endtask

    task automatic exp_r(input logic [1:0] a);
        bus_t b;
        b.rd = 1'b1; b.a = a; b.d = 8'h00;
        bus_q.push_back(b);
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] ch, input logic [1:0] rw,
                         input logic [2:0] mode, input logic bcd, input logic [15:0] count,
                         input int n_acc, input logic want_rsp, input logic err,
                         input logic chk_data, input logic [15:0] data, input logic [2:0] g);
        int   t;
        int   k;
        rsp_t r;
        @(negedge clk);
        req_op = op; req_ch = ch; req_rw = rw; req_mode = mode; req_bcd = bcd; req_count = count;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("accept_timeout", req_ready, 1'b1);
        t = cyc;
        if (want_rsp) begin
            r.err = err; r.chk_data = chk_data; r.data = data; r.gate = g;
            r.cyc = t + 1 + n_acc * (STB + 2);
            rsp_q.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'b11; req_ch = 2'b11; req_rw = 2'b00; req_mode = 3'b111; req_bcd = 1'b1;
        req_count = 16'hDEAD;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || !req_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(name, rsp_q.size() + bus_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int cs0;
    int base;
    int k;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_data", rsp_data, 16'h0000);
        chk("rst_gate", gate, 3'b000);
        chk("rst_di", pit_di, 8'h00);
        chk("rst_addr", {pit_a1, pit_a0}, 2'b00);
        chk("rst_strobes", {pit_cs, pit_wr, pit_rd}, 3'b111);
        reset = 1'b0;

        // PROGRAM ch0 rw=11 mode0 count=01FF
        exp_w(2'b11, 8'h30); exp_w(2'b00, 8'hFF); exp_w(2'b00, 8'h01);
        issue(OP_PROGRAM, 2'd0, RW_BOTH, 3'd0, 1'b0, 16'h01FF, 3, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000);
        // LATCH_READ ch0 rw=11; mode/bcd inputs must not leak into the latch command
        exp_w(2'b11, 8'h00); exp_r(2'b00); exp_r(2'b00);
        issue(OP_LATCH, 2'd0, RW_BOTH, 3'b101, 1'b1, 16'h0000, 3, 1'b1, 1'b0, 1'b1, 16'h1234, 3'b000);
        // PROGRAM ch2 rw=01 mode3 count=000F
        exp_w(2'b11, 8'h96); exp_w(2'b10, 8'h0F);
        issue(OP_PROGRAM, 2'd2, RW_LSB, 3'd3, 1'b0, 16'h000F, 2, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000);
        drain("drain_program");

        cs0 = cs_cycles;
        issue(OP_SET_GATE, 2'd1, RW_LATCH, 3'd0, 1'b0, 16'h0001, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b010);
        issue(OP_SET_GATE, 2'd1, RW_LATCH, 3'd0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000);
        issue(OP_SET_GATE, 2'd2, RW_BOTH,  3'd0, 1'b0, 16'hFFFF, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b100);
        issue(OP_PROGRAM,  2'd3, RW_BOTH,  3'd0, 1'b0, 16'h1111, 0, 1'b1, 1'b1, 1'b1, 16'h1234, 3'b100);
        issue(OP_RSVD,     2'd0, RW_BOTH,  3'd0, 1'b0, 16'h2222, 0, 1'b1, 1'b1, 1'b1, 16'h1234, 3'b100);
        issue(OP_PROGRAM,  2'd1, RW_LATCH, 3'd0, 1'b0, 16'h3333, 0, 1'b1, 1'b1, 1'b1, 16'h1234, 3'b100);
        issue(OP_LATCH,    2'd2, RW_LATCH, 3'd0, 1'b0, 16'h0000, 0, 1'b1, 1'b1, 1'b1, 16'h1234, 3'b100);
        issue(OP_SET_GATE, 2'd3, RW_LSB,   3'd0, 1'b0, 16'h0001, 0, 1'b1, 1'b1, 1'b1, 16'h1234, 3'b100);
        drain("drain_gate_err");
        chk("no_cs_activity", cs_cycles - cs0, 0);

        exp_w(2'b11, 8'h40); exp_r(2'b01);
        issue(OP_LATCH, 2'd1, RW_LSB, 3'd0, 1'b0, 16'h0000, 2, 1'b1, 1'b0, 1'b1, 16'h005A, 3'b100);
        exp_w(2'b11, 8'h80); exp_r(2'b10);
        issue(OP_LATCH, 2'd2, RW_MSB, 3'd0, 1'b0, 16'h0000, 2, 1'b1, 1'b0, 1'b1, 16'hC300, 3'b100);
        exp_w(2'b11, 8'h65); exp_w(2'b01, 8'hAB);
        issue(OP_PROGRAM, 2'd1, RW_MSB, 3'd2, 1'b1, 16'hAB00, 2, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b100);
        drain("drain_mixed");
        chk("cs_total", cs_cycles, 56);

        // Reset asserted during the WR_MSB strobe of a PROGRAM rw=11
        base = acc_seen;
        exp_w(2'b11, 8'h30); exp_w(2'b00, 8'h34); exp_w(2'b00, 8'h12);
        issue(OP_PROGRAM, 2'd0, RW_BOTH, 3'd0, 1'b0, 16'h1234, 3, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
        k = 0;
        while (acc_seen != base + 3 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("reached_wr_msb", acc_seen - base, 3);
        reset = 1'b1;
        #1;
        chk("abort_wr_inactive", pit_wr, 1'b1);
        chk("abort_cs_inactive", pit_cs, 1'b1);
        chk("abort_rd_inactive", pit_rd, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_reset_ready", req_ready, 1'b1);
        chk("post_reset_gate", gate, 3'b000);
        chk("post_reset_queues", rsp_q.size() + bus_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
